mio_bus_arbiter: RTL and testbench

- Shares the single MIO bus port (addr_bus / mem_w / Cpu_data2bus / Cpu_data4bus) between two masters: m0 (CPU) and m1 (secondary master, e.g. DMA or display fetch).
- Each master uses a level req / pulsed ack handshake.
- The arbiter grants round-robin and runs one access at a time, with a fixed wait-state count.
- It registers the bus outputs and captures read data.
- It sits between the masters and the MIO_BUS address decoder.

---
 rtl/mio_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter
//   Shares the single MIO bus port between two masters, m0 (CPU) and
//   m1 (secondary master such as DMA or display fetch). Each master holds
//   a level request until it receives a one-cycle ack pulse. One access
//   runs at a time, and grants alternate round-robin when both masters
//   are waiting. Every access spends WAIT_CYCLES extra cycles on the bus
//   before read data is sampled.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   m0_req/we/addr/wdata: m0 request, direction, byte address, write data
//   m0_ack              : one-cycle completion pulse to m0
//   m1_req/we/addr/wdata: m1 request, direction, byte address, write data
//   m1_ack              : one-cycle completion pulse to m1
//   rdata               : read data of the last completed access
//   addr_bus, mem_w,
//   Cpu_data2bus        : registered address, write strobe and write data
//                         driven to the MIO bus decoder
//   Cpu_data4bus        : read data returned by the MIO bus decoder
//   busy                : high while an access is in progress
//   gnt_id              : owner of the current/last access (0 = m0, 1 = m1)
// ---------------------------------------------------------------------------
module mio_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int CW          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] rdata,
  output logic [31:0] addr_bus,
  output logic        mem_w,
  output logic [31:0] Cpu_data2bus,
  input  logic [31:0] Cpu_data4bus,
  output logic        busy,
  output logic        gnt_id
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t          r_state,  w_state_next;
  logic [31:0]     r_addr,   w_addr_next;
  logic [31:0]     r_wdata,  w_wdata_next;
  logic [31:0]     r_rdata,  w_rdata_next;
  logic            r_mem_w,  w_mem_w_next;
  logic            r_m0_ack, w_m0_ack_next;
  logic            r_m1_ack, w_m1_ack_next;
  logic            r_gnt_id, w_gnt_id_next;
  logic            r_ptr,    w_ptr_next;
  logic [CW-1:0]   r_cnt,    w_cnt_next;

  logic            w_elig0;
  logic            w_elig1;
  logic            w_grant;
  logic            w_winner;

  // A master whose ack is still high has not had a chance to drop req yet;
  // treating it as ineligible prevents a spurious re-grant of the same access.
  assign w_elig0  = m0_req & ~r_m0_ack;
  assign w_elig1  = m1_req & ~r_m1_ack;
  assign w_grant  = w_elig0 | w_elig1;
  assign w_winner = (w_elig0 & w_elig1) ? r_ptr : w_elig1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_mem_w  <= 1'b0;
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_gnt_id <= 1'b0;
      r_ptr    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_addr   <= w_addr_next;
      r_wdata  <= w_wdata_next;
      r_rdata  <= w_rdata_next;
      r_mem_w  <= w_mem_w_next;
      r_m0_ack <= w_m0_ack_next;
      r_m1_ack <= w_m1_ack_next;
      r_gnt_id <= w_gnt_id_next;
      r_ptr    <= w_ptr_next;
      r_cnt    <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_rdata_next  = r_rdata;
    // Strobe and acks are single-cycle pulses; they default low every cycle.
    w_mem_w_next  = 1'b0;
    w_m0_ack_next = 1'b0;
    w_m1_ack_next = 1'b0;
    w_gnt_id_next = r_gnt_id;
    w_ptr_next    = r_ptr;
    w_cnt_next    = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next  = S_ACCESS;
          w_addr_next   = w_winner ? m1_addr  : m0_addr;
          w_wdata_next  = w_winner ? m1_wdata : m0_wdata;
          w_mem_w_next  = w_winner ? m1_we    : m0_we;
          w_gnt_id_next = w_winner;
          w_ptr_next    = ~w_winner;
          w_cnt_next    = CW'(WAIT_CYCLES);
        end else begin
          w_addr_next  = '0;
          w_wdata_next = '0;
        end
      end
      S_ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          // Read data is captured on writes too; the master simply ignores it.
          w_rdata_next  = Cpu_data4bus;
          w_m0_ack_next = ~r_gnt_id;
          w_m1_ack_next = r_gnt_id;
          w_addr_next   = '0;
          w_wdata_next  = '0;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign addr_bus     = r_addr;
  assign Cpu_data2bus = r_wdata;
  assign mem_w        = r_mem_w;
  assign rdata        = r_rdata;
  assign m0_ack       = r_m0_ack;
  assign m1_ack       = r_m1_ack;
  assign gnt_id       = r_gnt_id;
  assign busy         = (r_state == S_ACCESS);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mio_bus_arbiter
//   Directed bench for mio_bus_arbiter. A table of single-master
//   transactions is applied in a loop; reset, contention, request drop,
//   mid-access reset and a zero-wait-state instance are covered by short
//   hand-written sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mio_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_ack;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_we, m1_ack;
  logic [31:0] m1_addr, m1_wdata;
  logic [31:0] rdata, addr_bus, Cpu_data2bus, Cpu_data4bus;
  logic        mem_w, busy, gnt_id;

  // zero-wait-state instance
  logic        z_m0_req, z_m0_we, z_m0_ack;
  logic [31:0] z_m0_addr, z_m0_wdata;
  logic        z_m1_req, z_m1_we, z_m1_ack;
  logic [31:0] z_m1_addr, z_m1_wdata;
  logic [31:0] z_rdata, z_addr_bus, z_data2bus, z_data4bus;
  logic        z_mem_w, z_busy, z_gnt_id;

  int total = 0;
  int bad   = 0;

  mio_bus_arbiter #(.WAIT_CYCLES(1), .CW(4)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .addr_bus(addr_bus), .mem_w(mem_w), .Cpu_data2bus(Cpu_data2bus),
    .Cpu_data4bus(Cpu_data4bus), .busy(busy), .gnt_id(gnt_id)
  );

  mio_bus_arbiter #(.WAIT_CYCLES(0), .CW(4)) u_dut_z (
    .clk(clk), .rst(rst),
    .m0_req(z_m0_req), .m0_we(z_m0_we), .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata), .m0_ack(z_m0_ack),
    .m1_req(z_m1_req), .m1_we(z_m1_we), .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata), .m1_ack(z_m1_ack),
    .rdata(z_rdata), .addr_bus(z_addr_bus), .mem_w(z_mem_w), .Cpu_data2bus(z_data2bus),
    .Cpu_data4bus(z_data4bus), .busy(z_busy), .gnt_id(z_gnt_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbus;
    int          exp_ack_cyc;
    int          exp_busy;
    int          exp_memw;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input logic mst, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    if (mst) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic pb, pa0, pa1;
    int   ng, n_ack0, n_ack1, dbl, regrant_bad;
    logic [3:0]  gseq;
    logic [31:0] gaddr0, gaddr1;
    int   ack_cyc, busy_n, memw_n, addr_bad, wd_bad, other_ack, ack_n;
    logic mine;

    vecs[0] = '{mst:1'b0, we:1'b0, addr:32'h00000004, wdata:32'h00000000, rbus:32'hffffeeee,
                exp_ack_cyc:3, exp_busy:2, exp_memw:0, exp_rdata:32'hffffeeee};
    vecs[1] = '{mst:1'b1, we:1'b1, addr:32'hffff0100, wdata:32'heeeeaaaa, rbus:32'h12345678,
                exp_ack_cyc:3, exp_busy:2, exp_memw:1, exp_rdata:32'h12345678};
    vecs[2] = '{mst:1'b0, we:1'b1, addr:32'hffff0210, wdata:32'ha5a5a5a5, rbus:32'h00000000,
                exp_ack_cyc:3, exp_busy:2, exp_memw:1, exp_rdata:32'h00000000};
    vecs[3] = '{mst:1'b1, we:1'b0, addr:32'h00000008, wdata:32'h0000abcd, rbus:32'hdeadbeef,
                exp_ack_cyc:3, exp_busy:2, exp_memw:0, exp_rdata:32'hdeadbeef};

    z_m0_req = 0; z_m0_we = 0; z_m0_addr = 0; z_m0_wdata = 0;
    z_m1_req = 0; z_m1_we = 0; z_m1_addr = 0; z_m1_wdata = 0; z_data4bus = 0;

    // ---- reset with both requests held, then contention ----
    rst = 1'b1;
    Cpu_data4bus = 32'h0;
    set_master(1'b0, 1'b1, 1'b0, 32'hffff0210, 32'h0);
    set_master(1'b1, 1'b1, 1'b0, 32'h00000008, 32'h0);
    #100;
    chk("rst_m0_ack", {31'b0, m0_ack}, 32'd0);
    chk("rst_m1_ack", {31'b0, m1_ack}, 32'd0);
    chk("rst_addr", addr_bus, 32'h0);
    chk("rst_mem_w", {31'b0, mem_w}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    pb = 0; pa0 = 0; pa1 = 0; ng = 0; n_ack0 = 0; n_ack1 = 0; dbl = 0; regrant_bad = 0;
    gseq = '0; gaddr0 = '0; gaddr1 = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        chk("first_gnt_busy", {31'b0, busy}, 32'd1);
        chk("first_gnt_id", {31'b0, gnt_id}, 32'd0);
      end
      if (busy && !pb) begin
        if (ng < 4) gseq[ng] = gnt_id;
        if (ng == 0) gaddr0 = addr_bus;
        if (ng == 1) gaddr1 = addr_bus;
        if ((gnt_id == 1'b0 && pa0) || (gnt_id == 1'b1 && pa1)) regrant_bad++;
        ng++;
      end
      if (m0_ack) n_ack0++;
      if (m1_ack) n_ack1++;
      if ((m0_ack && pa0) || (m1_ack && pa1)) dbl++;
      pb = busy; pa0 = m0_ack; pa1 = m1_ack;
    end
    m0_req = 0; m1_req = 0;
    chk("cont_grants", 32'(ng), 32'd4);
    chk("cont_seq", {28'b0, gseq}, 32'h0000000a);
    chk("cont_addr0", gaddr0, 32'hffff0210);
    chk("cont_addr1", gaddr1, 32'h00000008);
    chk("cont_ack0_n", 32'(n_ack0), 32'd2);
    chk("cont_ack1_n", 32'(n_ack1), 32'd2);
    chk("cont_ack_wide", 32'(dbl), 32'd0);
    chk("cont_regrant", 32'(regrant_bad), 32'd0);
    tick(); tick();
    chk("cont_drain_busy", {31'b0, busy}, 32'd0);

    // ---- table-driven single transactions ----
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      Cpu_data4bus = v.rbus;
      set_master(v.mst, 1'b1, v.we, v.addr, v.wdata);
      ack_cyc = 0; busy_n = 0; memw_n = 0; addr_bad = 0; wd_bad = 0; other_ack = 0; ack_n = 0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (busy) begin
          busy_n++;
          if (addr_bus !== v.addr) addr_bad++;
          if (Cpu_data2bus !== v.wdata) wd_bad++;
        end
        if (mem_w) memw_n++;
        mine = v.mst ? m1_ack : m0_ack;
        if (mine) begin
          ack_n++;
          if (ack_cyc == 0) begin
            ack_cyc = c;
            chk($sformatf("v%0d_rdata", i), rdata, v.exp_rdata);
            chk($sformatf("v%0d_gnt_id", i), {31'b0, gnt_id}, {31'b0, v.mst});
          end
          set_master(v.mst, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        if (v.mst ? m0_ack : m1_ack) other_ack++;
        // inputs changing mid-access must not disturb the latched values
        if (c == 1) set_master(v.mst, 1'b1, ~v.we, ~v.addr, ~v.wdata);
      end
      set_master(v.mst, 1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("v%0d_ack_cyc", i), 32'(ack_cyc), 32'(v.exp_ack_cyc));
      chk($sformatf("v%0d_busy_n", i), 32'(busy_n), 32'(v.exp_busy));
      chk($sformatf("v%0d_memw_n", i), 32'(memw_n), 32'(v.exp_memw));
      chk($sformatf("v%0d_addr_bad", i), 32'(addr_bad), 32'd0);
      chk($sformatf("v%0d_wdata_bad", i), 32'(wd_bad), 32'd0);
      chk($sformatf("v%0d_ack_n", i), 32'(ack_n), 32'd1);
      chk($sformatf("v%0d_other_ack", i), 32'(other_ack), 32'd0);
      $display("txn %0d: master=%0d we=%0d addr=%h ack_cyc=%0d rdata=%h",
               i, v.mst, v.we, v.addr, ack_cyc, rdata);
    end

    // ---- req dropped one cycle after grant ----
    Cpu_data4bus = 32'h0badf00d;
    set_master(1'b0, 1'b1, 1'b0, 32'h00000040, 32'h0);
    ack_cyc = 0; busy_n = 0; ack_n = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (busy) busy_n++;
      if (m0_ack) begin
        ack_n++;
        if (ack_cyc == 0) begin
          ack_cyc = c;
          chk("drop_rdata", rdata, 32'h0badf00d);
        end
      end
      if (c == 1) m0_req = 1'b0;
    end
    chk("drop_ack_cyc", 32'(ack_cyc), 32'd3);
    chk("drop_ack_n", 32'(ack_n), 32'd1);
    chk("drop_busy_n", 32'(busy_n), 32'd2);
    $display("txn drop: ack_cyc=%0d busy_cycles=%0d", ack_cyc, busy_n);

    // ---- reset during a write access ----
    set_master(1'b0, 1'b1, 1'b1, 32'hffff021a, 32'h5555aaaa);
    tick();
    chk("mrst_pre_busy", {31'b0, busy}, 32'd1);
    chk("mrst_pre_memw", {31'b0, mem_w}, 32'd1);
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_master(1'b1, 1'b1, 1'b0, 32'h00000020, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_memw", {31'b0, mem_w}, 32'd0);
    chk("mrst_addr", addr_bus, 32'h0);
    chk("mrst_wdata", Cpu_data2bus, 32'h0);
    ack_n = 0;
    tick(); if (m0_ack || m1_ack) ack_n++;
    tick(); if (m0_ack || m1_ack) ack_n++;
    chk("mrst_no_ack", 32'(ack_n), 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst_gnt_busy", {31'b0, busy}, 32'd1);
    chk("mrst_gnt_id", {31'b0, gnt_id}, 32'd1);
    chk("mrst_gnt_addr", addr_bus, 32'h00000020);
    tick(); tick();
    chk("mrst_m1_ack", {31'b0, m1_ack}, 32'd1);
    chk("mrst_m0_ack", {31'b0, m0_ack}, 32'd0);
    m1_req = 1'b0;
    $display("txn mrst: m1 granted after reset, ack=%0d", m1_ack);
    tick();

    // ---- zero wait states: one ACCESS cycle, strobe still single-cycle ----
    z_data4bus = 32'h00000077;
    z_m1_req = 1'b1; z_m1_we = 1'b1; z_m1_addr = 32'h00000100; z_m1_wdata = 32'hcafe0001;
    tick();
    chk("z_c1_busy", {31'b0, z_busy}, 32'd1);
    chk("z_c1_memw", {31'b0, z_mem_w}, 32'd1);
    chk("z_c1_wdata", z_data2bus, 32'hcafe0001);
    chk("z_c1_ack", {31'b0, z_m1_ack}, 32'd0);
    tick();
    chk("z_c2_ack", {31'b0, z_m1_ack}, 32'd1);
    chk("z_c2_busy", {31'b0, z_busy}, 32'd0);
    chk("z_c2_memw", {31'b0, z_mem_w}, 32'd0);
    chk("z_c2_rdata", z_rdata, 32'h00000077);
    z_m1_req = 1'b0;
    tick();
    chk("z_c3_ack", {31'b0, z_m1_ack}, 32'd0);
    chk("z_c3_busy", {31'b0, z_busy}, 32'd0);
    $display("txn zero_wait: write addr=%h rdata=%h", z_m1_addr, z_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
